// File: rtl/vga_sync_rx_if.sv
// vga_sync_rx_if
//   Bundles the incoming VGA sync pair and the recovered raster outputs.
//   master : drives hsync/vsync and observes the recovered raster
//            (a sync source, or a bench).
//   slave  : the receiver; samples hsync/vsync and drives everything else.
//   Signals:
//     hsync, vsync  active-low sync inputs, asynchronous to the receiver clock
//     pixel_x/y     recovered raster position
//     pix_tick      one-clock pixel strobe
//     video_on      active-area flag, only while locked
//     locked        stream tracked in both axes
//     sync_err      one-clock pulse per timing mismatch seen while locked
//     err_count     saturating count of sync_err pulses
//     dbg_state     receiver FSM state (0 SEARCH, 1 H_TRACK, 2 V_TRACK, 3 LOCKED)
interface vga_sync_rx_if;
   logic       hsync;
   logic       vsync;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       pix_tick;
   logic       video_on;
   logic       locked;
   logic       sync_err;
   logic [7:0] err_count;
   logic [1:0] dbg_state;

   modport master (
      output hsync, vsync,
      input  pixel_x, pixel_y, pix_tick, video_on, locked, sync_err,
             err_count, dbg_state
   );

   modport slave (
      input  hsync, vsync,
      output pixel_x, pixel_y, pix_tick, video_on, locked, sync_err,
             err_count, dbg_state
   );
endinterface

// File: rtl/vga_sync_rx.sv
// vga_sync_rx
//   Recovers pixel phase and raster position from an incoming active-low
//   hsync/vsync pair, locks onto it and reports timing errors while locked.
//   Ports:
//     clk  system clock (DIV clocks per pixel)
//     rst  asynchronous active-high reset
//     bus  vga_sync_rx_if.slave: sync inputs in, raster/status outputs out
module vga_sync_rx #(
   parameter int DIV          = 4,
   parameter int H_TOTAL      = 800,
   parameter int H_ACTIVE     = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_WIDTH = 96,
   parameter int V_TOTAL      = 525,
   parameter int V_ACTIVE     = 480,
   parameter int V_SYNC_START = 490,
   parameter int LOCK_LINES   = 4
) (
   input  logic         clk,
   input  logic         rst,
   vga_sync_rx_if.slave bus
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int GW = $clog2(LOCK_LINES + 1);
   localparam logic [PW-1:0] P_LAST    = PW'(DIV - 1);
   localparam logic [9:0]    X_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]    HS_FALL_X = 10'(H_SYNC_START);
   localparam logic [9:0]    HS_RISE_X = 10'(H_SYNC_START + H_SYNC_WIDTH);
   localparam logic [9:0]    VS_FALL_Y = 10'(V_SYNC_START);
   localparam logic [9:0]    X_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]    Y_ACT     = 10'(V_ACTIVE);
   localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_LINES);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      H_TRACK = 2'd1,
      V_TRACK = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   good_q, good_d;
   logic [PW-1:0]   p_q, p_d, p_e;
   logic [9:0]      x_q, x_d, x_e;
   logic [9:0]      y_q, y_d, y_e;
   logic            hs_meta_q, hs_sync_q, hs_last_q;
   logic            vs_meta_q, vs_sync_q, vs_last_q;
   logic            h_seen_q, h_seen_d, v_seen_q, v_seen_d;
   logic            locked_q, sync_err_q, err_d;
   logic [7:0]      err_cnt_q;
   logic            h_rl, v_rl;
   logic            pix_tick;
   logic            hs_fall, hs_rise, vs_fall;
   logic            h_fall_ok, h_rise_ok, v_fall_ok;
   logic            h_miss, v_miss, h_bad, v_bad;

   // Two-flop synchronizers plus one edge register; idle level is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_meta_q <= 1'b1;
         hs_sync_q <= 1'b1;
         hs_last_q <= 1'b1;
         vs_meta_q <= 1'b1;
         vs_sync_q <= 1'b1;
         vs_last_q <= 1'b1;
      end else begin
         hs_meta_q <= bus.hsync;
         hs_sync_q <= hs_meta_q;
         hs_last_q <= hs_sync_q;
         vs_meta_q <= bus.vsync;
         vs_sync_q <= vs_meta_q;
         vs_last_q <= vs_sync_q;
      end
   end

   assign hs_fall  = hs_last_q & ~hs_sync_q;
   assign hs_rise  = ~hs_last_q & hs_sync_q;
   assign vs_fall  = vs_last_q & ~vs_sync_q;
   assign pix_tick = (p_q == P_LAST);

   // Edge checks use the counters as they stand, before any reload.
   assign h_fall_ok = (x_q == HS_FALL_X) && (p_q == '0);
   assign h_rise_ok = (x_q == HS_RISE_X) && (p_q == '0);
   assign v_fall_ok = (y_q == VS_FALL_Y) && (x_q == '0) && (p_q == '0);

   // A line (frame) with no sync fall is caught at the last clock of the
   // pixel where that fall should have been seen.
   assign h_miss = pix_tick && (x_q == HS_FALL_X) && !h_seen_q && !hs_fall;
   assign v_miss = pix_tick && (x_q == '0) && (y_q == VS_FALL_Y) &&
                   !v_seen_q && !vs_fall;
   assign h_bad  = (hs_fall && !h_fall_ok) || (hs_rise && !h_rise_ok) || h_miss;
   assign v_bad  = (vs_fall && !v_fall_ok) || v_miss;

   always_comb begin
      h_seen_d = h_seen_q;
      v_seen_d = v_seen_q;
      if (hs_fall)                             h_seen_d = 1'b1;
      else if (pix_tick && (x_q == HS_FALL_X)) h_seen_d = 1'b0;
      if (vs_fall)                                             v_seen_d = 1'b1;
      else if (pix_tick && (x_q == '0) && (y_q == VS_FALL_Y)) v_seen_d = 1'b0;
   end

   // Next state. Horizontal events are resolved before vertical ones, so a
   // vsync fall in H_TRACK sees the good-line count already updated.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      h_rl    = 1'b0;
      v_rl    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         SEARCH: begin
            if (hs_fall) begin
               h_rl    = 1'b1;
               good_d  = '0;
               state_d = H_TRACK;
            end
         end
         H_TRACK: begin
            if (hs_fall) begin
               if (h_fall_ok) begin
                  if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
               end else begin
                  h_rl   = 1'b1;
                  good_d = '0;
               end
            end
            if (vs_fall && (good_d == GOOD_MAX)) begin
               v_rl    = 1'b1;
               state_d = V_TRACK;
            end
         end
         V_TRACK: begin
            if (h_bad) begin
               h_rl    = hs_fall;
               good_d  = '0;
               state_d = H_TRACK;
            end else if (vs_fall) begin
               if (v_fall_ok) state_d = LOCKED;
               else           v_rl    = 1'b1;
            end
         end
         LOCKED: begin
            if (h_bad || v_bad) begin
               err_d = 1'b1;
               // An offending hsync fall doubles as the new acquisition edge.
               if (hs_fall) begin
                  h_rl    = 1'b1;
                  good_d  = '0;
                  state_d = H_TRACK;
               end else begin
                  state_d = SEARCH;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // A reload makes the current clock count as pixel phase 0 of the sync
   // position, so an in-phase reload leaves the counters undisturbed.
   always_comb begin
      p_e = h_rl ? '0 : p_q;
      x_e = h_rl ? HS_FALL_X : x_q;
      y_e = v_rl ? VS_FALL_Y : y_q;
      p_d = p_e + 1'b1;
      x_d = x_e;
      y_d = y_e;
      if (p_e == P_LAST) begin
         p_d = '0;
         if (x_e == X_LAST) begin
            x_d = '0;
            y_d = (y_e == Y_LAST) ? '0 : y_e + 1'b1;
         end else begin
            x_d = x_e + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SEARCH;
         good_q     <= '0;
         p_q        <= '0;
         x_q        <= '0;
         y_q        <= '0;
         h_seen_q   <= 1'b0;
         v_seen_q   <= 1'b0;
         locked_q   <= 1'b0;
         sync_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         good_q     <= good_d;
         p_q        <= p_d;
         x_q        <= x_d;
         y_q        <= y_d;
         h_seen_q   <= h_seen_d;
         v_seen_q   <= v_seen_d;
         locked_q   <= (state_d == LOCKED);
         sync_err_q <= err_d;
         if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign bus.pixel_x   = x_q;
   assign bus.pixel_y   = y_q;
   assign bus.pix_tick  = pix_tick;
   assign bus.video_on  = locked_q && (x_q < X_ACT) && (y_q < Y_ACT);
   assign bus.locked    = locked_q;
   assign bus.sync_err  = sync_err_q;
   assign bus.err_count = err_cnt_q;
   assign bus.dbg_state = state_q;
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the team's 640x480@60 VGA timing generator.
- Samples incoming hsync/vsync (active-low) in the 100 MHz system clock domain and recovers the 25 MHz pixel phase and the pixel_x/pixel_y raster position.
- Checks the incoming stream against the configured timing, locks onto it, and reports sync errors.
- Used on capture and loopback paths, and as a monitor on the generator's own outputs.

Parameters:
- DIV, 4, system clocks per pixel tick.
- H_TOTAL, 800, pixel ticks per line.
- H_ACTIVE, 640, active pixels per line.
- H_SYNC_START, 656, pixel_x at which hsync falls.
- H_SYNC_WIDTH, 96, hsync low width in ticks.
- V_TOTAL, 525, lines per frame.
- V_ACTIVE, 480, active lines per frame.
- V_SYNC_START, 490, line at which vsync falls.
- LOCK_LINES, 4, consecutive good hsync falling edges required before vertical acquisition.

Ports:
- clk, input, 1, 100 MHz system clock.
- rst, input, 1, reset; asynchronous, active-high.
- hsync, input, 1, incoming horizontal sync, active-low, asynchronous to clk phase.
- vsync, input, 1, incoming vertical sync, active-low.
- pixel_x, output, 10, recovered column, 0..H_TOTAL-1.
- pixel_y, output, 10, recovered line, 0..V_TOTAL-1.
- pix_tick, output, 1, recovered pixel strobe, high one clk per DIV clks.
- video_on, output, 1, high when locked and pixel_x<H_ACTIVE and pixel_y<V_ACTIVE.
- locked, output, 1, stream tracked in both axes.
- sync_err, output, 1, one-clk pulse on any timing mismatch while locked.
- err_count, output, 8, saturating count of sync_err pulses.

Behaviour:
- Input conditioning:
  - hsync and vsync each pass through a 2-FF synchronizer, then an edge-detect register.
  - fall/rise flags are valid 2 clks after the input pin changes.
- Phase and position counters:
  - phase counter p runs 0..DIV-1; pix_tick = (p==DIV-1).
  - pixel_x increments on pix_tick and wraps H_TOTAL-1 -> 0.
  - pixel_y increments when pixel_x wraps, and wraps V_TOTAL-1 -> 0.
- "In phase" checks, evaluated on the counter values before any reload:
  - hsync fall is in phase iff pixel_x==H_SYNC_START and p==0.
  - hsync rise is in phase iff pixel_x==H_SYNC_START+H_SYNC_WIDTH and p==0.
  - vsync fall is in phase iff pixel_y==V_SYNC_START and pixel_x==0 and p==0.
- Missing-edge detection:
  - A missing hsync fall is flagged on the pix_tick at which pixel_x==H_SYNC_START, when no hsync fall occurred since the previous such tick.
  - A missing vsync fall is flagged analogously, once per frame at pixel_y==V_SYNC_START.
- Reload values:
  - On hsync fall: p<=0, pixel_x<=H_SYNC_START.
  - On vsync fall: pixel_y<=V_SYNC_START.
- FSM states: SEARCH, H_TRACK, V_TRACK, LOCKED.
  - SEARCH: reset state. Counters free-run. The first hsync fall triggers an h reload, clears good_cnt, and moves to H_TRACK.
  - H_TRACK: an in-phase hsync fall increments good_cnt (saturating at LOCK_LINES). An out-of-phase fall reloads h and clears good_cnt. On a vsync fall with good_cnt==LOCK_LINES: reload v, move to V_TRACK. A vsync fall with good_cnt<LOCK_LINES is ignored.
  - V_TRACK: an in-phase vsync fall moves to LOCKED. An out-of-phase vsync fall reloads v and stays. Any horizontal mismatch returns to H_TRACK with an h reload and good_cnt cleared.
  - LOCKED: any out-of-phase edge or missing edge pulses sync_err for 1 clk, increments err_count (saturating at 255), and moves to SEARCH. The offending edge is used as that SEARCH acquisition edge: h reload, state becomes H_TRACK.
- Output timing:
  - locked is registered: high the clk after entering LOCKED, low the clk after leaving it.
  - video_on is forced low whenever locked is low.
- Simultaneous events:
  - hsync fall and vsync fall in the same clk: h checks and reload are processed first.
  - The vsync check uses the pre-reload pixel_x (0 expected). Both reloads apply.
- Reset values:
  - Asserting rst at any time forces pixel_x=0, pixel_y=0, p=0, state=SEARCH.
  - locked=0, video_on=0, sync_err=0, err_count=0, pix_tick=0, synchronizer and edge registers=1 (idle-high sync).
  - Release resumes from SEARCH.

Test Plan:
- Drive from a reference generator model (100 MHz, both blocks released from reset on the same clk; generator hsync falls at clk 2624, vsync at clk 1,568,000) -> locked rises at clk 3,248,003. Thereafter pixel_x/pixel_y equal the generator counts delayed 2 clks, video_on matches, and err_count stays 0 over 3 frames.
- While locked, delay one hsync fall by 1 clk -> sync_err pulse one clk after the late edge is detected. err_count becomes 1, locked drops, state H_TRACK. Relock follows at the second subsequent in-phase vsync.
- While locked, suppress one hsync pulse entirely -> sync_err on the pix_tick at pixel_x==656 of that line; locked low.
- Shorten the hsync low width to 95 ticks while locked -> sync_err at the rise edge; err_count increments by 1.
- Feed a stream with H_TOTAL=801 -> never leaves H_TRACK, locked stays 0, and sync_err stays 0 (errors are only counted in LOCKED).
- Assert rst mid-frame while locked -> all outputs return to reset values immediately (asynchronously). After release, the 3,248,003-clk lock sequence repeats relative to a generator restarted in the same clk.
